// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the data-memory load/store unit.
// Size decoding lives here so the align logic and any future users agree.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Undefined encodings fall back to a full-word access.
   function automatic lsu_size_t f3_size(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LBU: f3_size = SZ_B;
         F3_LH, F3_LHU: f3_size = SZ_H;
         F3_LW:         f3_size = SZ_W;
         default:       f3_size = SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store-side alignment check, byte enables and data
// replication, plus load-side lane select with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        i_func3,
   input  logic [1:0]        i_addr_lo,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_misaligned,
   output logic [3:0]        o_be,
   output logic [DATA_W-1:0] o_wdata,
   input  logic [2:0]        i_ld_func3,
   input  logic [1:0]        i_ld_offset,
   input  logic [DATA_W-1:0] i_raw,
   output logic [DATA_W-1:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sext;

   always_comb begin
      o_misaligned = 1'b0;
      o_be         = 4'b1111;
      o_wdata      = i_wr_data;
      case (f3_size(i_func3))
         SZ_B: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wr_data[7:0]}};
         end
         SZ_H: begin
            o_misaligned = i_addr_lo[0];
            o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata      = {2{i_wr_data[15:0]}};
         end
         default: o_misaligned = |i_addr_lo;
      endcase
   end

   // Load side works from the offset/func3 latched when the access started.
   always_comb begin
      w_byte = i_raw[7:0];
      case (i_ld_offset)
         2'd1:    w_byte = i_raw[15:8];
         2'd2:    w_byte = i_raw[23:16];
         2'd3:    w_byte = i_raw[31:24];
         default: w_byte = i_raw[7:0];
      endcase
      w_half    = i_ld_offset[1] ? i_raw[31:16] : i_raw[15:0];
      w_sext    = ~i_ld_func3[2];
      o_ld_data = i_raw;
      case (f3_size(i_ld_func3))
         SZ_B:    o_ld_data = {{(DATA_W-8){w_byte[7] & w_sext}}, w_byte};
         SZ_H:    o_ld_data = {{(DATA_W-16){w_half[15] & w_sext}}, w_half};
         default: o_ld_data = i_raw;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: drives a req/gnt/rvalid word memory from the EX/MEM request
// and stalls the pipeline until the access completes.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic                  stall,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  misalign,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DM_ADDRESS-3:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata
);

   lsu_state_t              r_state;
   lsu_state_t              w_next;
   logic                    r_mem_req;
   logic                    r_mem_we;
   logic [DM_ADDRESS-3:0]   r_mem_addr;
   logic [3:0]              r_mem_be;
   logic [DATA_W-1:0]       r_mem_wdata;
   logic [DATA_W-1:0]       r_rd_data;
   logic [1:0]              r_off;
   logic [2:0]              r_f3;

   logic                    w_req;
   logic                    w_mis;
   logic                    w_start;
   logic                    w_mis_req;
   logic [3:0]              w_be;
   logic [DATA_W-1:0]       w_wdata;
   logic [DATA_W-1:0]       w_ld_data;

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .i_func3      (func3),
      .i_addr_lo    (addr[1:0]),
      .i_wr_data    (wr_data),
      .o_misaligned (w_mis),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .i_ld_func3   (r_f3),
      .i_ld_offset  (r_off),
      .i_raw        (mem_rdata),
      .o_ld_data    (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // DONE deliberately ignores the still-present request so the pipeline can advance.
   always_comb begin
      w_req     = MemRead | MemWrite;
      w_start   = (r_state == IDLE) && w_req && !w_mis;
      w_mis_req = (r_state == IDLE) && w_req && w_mis;
      w_next    = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = REQ;
         REQ:     if (mem_gnt) w_next = r_mem_we ? DONE : WAIT;
         WAIT:    if (mem_rvalid) w_next = DONE;
         default: w_next = IDLE;
      endcase
      stall    = !reset && (w_start || (r_state == REQ) || (r_state == WAIT));
      misalign = !reset && w_mis_req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rd_data   <= '0;
         r_off       <= '0;
         r_f3        <= '0;
      end else begin
         if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWrite;
            r_mem_addr  <= addr[DM_ADDRESS-1:2];
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_off       <= addr[1:0];
            r_f3        <= func3;
         end else if ((r_state == REQ) && mem_gnt) begin
            r_mem_req <= 1'b0;
         end
         if (w_mis_req)
            r_rd_data <= '0;
         else if ((r_state == WAIT) && mem_rvalid)
            r_rd_data <= w_ld_data;
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a scripted memory answers each access with a
// chosen gnt/rvalid delay; expected values are hand-computed constants.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  func3;
   logic        stall;
   logic [31:0] rd_data;
   logic        misalign;
   logic        mem_req;
   logic        mem_we;
   logic [6:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .addr       (addr),
      .wr_data    (wr_data),
      .func3      (func3),
      .stall      (stall),
      .rd_data    (rd_data),
      .misalign   (misalign),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full access: present request, play memory, count stall cycles, check DONE.
   task automatic run_op(input string tag, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input int gdly, input int rdly, input logic [31:0] rword,
                         input int exp_stall, input logic [6:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd);
      int  st;
      int  gc;
      int  rc;
      bit  granted;
      bit  finished;
      st = 0; gc = 0; rc = 0; granted = 0; finished = 0;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; addr = a; wr_data = wd; func3 = f3;
      #1 chk({tag, " misalign"}, {31'b0, misalign}, 32'd0);
      for (int cyc = 0; cyc < 40; cyc++) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
         if (mem_req) begin
            chk({tag, " we"},    {31'b0, mem_we}, {31'b0, wr});
            chk({tag, " addr"},  {25'b0, mem_addr}, {25'b0, exp_addr});
            chk({tag, " be"},    {28'b0, mem_be}, {28'b0, exp_be});
            chk({tag, " wdata"}, mem_wdata, exp_wd);
            if (gc == gdly) begin
               mem_gnt = 1'b1;
               granted = 1;
            end
            gc++;
         end else if (granted && !wr) begin
            rc++;
            if (rc == rdly) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rword;
            end
         end
         #1;
         if (!stall) begin
            finished = 1;
            break;
         end
         st++;
         @(negedge clk);
      end
      if (!finished) begin
         n_checks++;
         n_errors++;
         $error("FAIL %s timeout: observed stall stuck, expected release", tag);
      end
      chk({tag, " stall_cycles"}, st, exp_stall);
      chk({tag, " req_done"}, {31'b0, mem_req}, 32'd0);
      chk({tag, " rd_data"}, rd_data, exp_rd);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   initial begin
      reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 9'h000;
      wr_data = 32'h0; func3 = 3'b010;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

      // Reset state, including stall forced low with a request present
      repeat (2) @(negedge clk);
      #1;
      chk("rst stall",    {31'b0, stall}, 32'd0);
      chk("rst mem_req",  {31'b0, mem_req}, 32'd0);
      chk("rst mem_we",   {31'b0, mem_we}, 32'd0);
      chk("rst mem_addr", {25'b0, mem_addr}, 32'd0);
      chk("rst mem_be",   {28'b0, mem_be}, 32'd0);
      chk("rst wdata",    mem_wdata, 32'd0);
      chk("rst rd_data",  rd_data, 32'd0);
      chk("rst misalign", {31'b0, misalign}, 32'd0);
      MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Stores
      run_op("SW", 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0, 32'h0,
             2, 7'h04, 4'b1111, 32'hDEADBEEF, 32'h0);
      run_op("SB", 0, 1, 9'h013, 32'h000000A5, 3'b000, 0, 0, 32'h0,
             2, 7'h04, 4'b1000, 32'hA5A5A5A5, 32'h0);
      run_op("SH", 0, 1, 9'h006, 32'h1234BEEF, 3'b001, 0, 0, 32'h0,
             2, 7'h01, 4'b1100, 32'hBEEFBEEF, 32'h0);

      // Loads
      run_op("LB", 1, 0, 9'h012, 32'h0, 3'b000, 0, 3, 32'h1280FF34,
             5, 7'h04, 4'b0100, 32'h0, 32'hFFFFFF80);
      run_op("LBU", 1, 0, 9'h012, 32'h0, 3'b100, 0, 3, 32'h1280FF34,
             5, 7'h04, 4'b0100, 32'h0, 32'h00000080);
      run_op("LH", 1, 0, 9'h002, 32'h0, 3'b001, 0, 1, 32'h80017FFF,
             3, 7'h00, 4'b1100, 32'h0, 32'hFFFF8001);
      run_op("LHU", 1, 0, 9'h000, 32'h0, 3'b101, 0, 2, 32'h80017FFF,
             4, 7'h00, 4'b0011, 32'h0, 32'h00007FFF);

      // A store leaves the previous load result in place
      run_op("SW_hold", 0, 1, 9'h1FC, 32'h01234567, 3'b010, 1, 0, 32'h0,
             3, 7'h7F, 4'b1111, 32'h01234567, 32'h00007FFF);

      // Misaligned word: no access, one-cycle pulse, rd_data cleared
      @(negedge clk);
      MemRead = 1'b1; addr = 9'h006; func3 = 3'b010;
      #1;
      chk("LW_mis misalign", {31'b0, misalign}, 32'd1);
      chk("LW_mis stall",    {31'b0, stall}, 32'd0);
      chk("LW_mis mem_req",  {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      MemRead = 1'b0;
      #1;
      chk("LW_mis rd_data",  rd_data, 32'd0);
      chk("LW_mis pulse",    {31'b0, misalign}, 32'd0);
      chk("LW_mis no_req",   {31'b0, mem_req}, 32'd0);

      // Odd halfword address is misaligned
      @(negedge clk);
      MemRead = 1'b1; addr = 9'h001; func3 = 3'b001;
      #1;
      chk("LH_mis misalign", {31'b0, misalign}, 32'd1);
      chk("LH_mis stall",    {31'b0, stall}, 32'd0);
      @(negedge clk);
      MemRead = 1'b0;

      // gnt withheld 4 cycles: outputs stable, stall held
      run_op("LW_slow", 1, 0, 9'h008, 32'h0, 3'b010, 4, 1, 32'hCAFEF00D,
             7, 7'h02, 4'b1111, 32'h0, 32'hCAFEF00D);

      // Reset while in WAIT; a late rvalid must be ignored
      @(negedge clk);
      MemRead = 1'b1; addr = 9'h00C; func3 = 3'b010;
      @(negedge clk);
      #1 chk("RST_WAIT req", {31'b0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      #1 chk("RST_WAIT stall_wait", {31'b0, stall}, 32'd1);
      reset = 1'b1;
      #1 chk("RST_WAIT stall_rst", {31'b0, stall}, 32'd0);
      @(negedge clk);
      reset = 1'b0; MemRead = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
      #1;
      chk("RST_WAIT mem_req", {31'b0, mem_req}, 32'd0);
      chk("RST_WAIT rd_data", rd_data, 32'd0);
      chk("RST_WAIT stall",   {31'b0, stall}, 32'd0);
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #1;
      chk("RST_WAIT late_rv", rd_data, 32'd0);
      chk("RST_WAIT idle",    {31'b0, mem_req}, 32'd0);

      // Normal operation resumes
      run_op("LW_after", 1, 0, 9'h00C, 32'h0, 3'b010, 0, 1, 32'h12345678,
             3, 7'h03, 4'b1111, 32'h0, 32'h12345678);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit on the downstream side of the pipeline's memory stage. It takes the EX/MEM memory request (read/write enables, byte address, store data, funct3) and runs it against a word-organised data memory that answers in a variable number of cycles over a req/gnt/rvalid handshake. While an access is in flight it stalls the pipeline. It produces sign- or zero-extended load data and flags misaligned accesses.

## Interface
Parameters:
- DM_ADDRESS, 9, byte address width from the pipeline
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM
- addr  in  DM_ADDRESS  byte address (ALU result)
- wr_data  in  DATA_W  store data (forwarded rs2)
- func3  in  3  access size/sign
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- rd_data  out  DATA_W  extended load result; registered
- misalign  out  1  one-cycle pulse on a misaligned request
- mem_req  out  1  memory request; registered
- mem_we  out  1  1 = write; registered
- mem_addr  out  DM_ADDRESS-2  word address addr[DM_ADDRESS-1:2]; registered
- mem_be  out  4  byte enables; registered
- mem_wdata  out  DATA_W  lane-replicated store data; registered
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid; never in the same cycle as gnt
- mem_rdata  in  DATA_W  raw read word

## Operation
- Request present = MemRead | MemWrite. When both are set, write wins.
- Alignment rules:
  - func3 000/100 (byte) is always aligned.
  - func3 001/101 (half) is misaligned when addr[0]=1.
  - All other func3 values (word) are misaligned when addr[1:0]≠0.
- Misaligned request in IDLE: no memory access. misalign=1 for that cycle, stall=0, rd_data←0.
- FSM states and transitions:
  - IDLE: on an aligned request, register mem_req=1, mem_we, mem_addr, mem_be and mem_wdata, then go to REQ.
  - REQ: hold mem_req and all mem_* stable until mem_gnt. On gnt: mem_req←0; a write goes to DONE, a read goes to WAIT.
  - WAIT: on mem_rvalid, rd_data←extend(mem_rdata), then go to DONE. Any mem_rvalid seen outside WAIT is ignored.
  - DONE: stall=0 for one cycle so the pipeline advances; the still-present old request is ignored. Next state is IDLE.
- stall is combinational and equals 1 when either:
  - state is IDLE with an aligned request, or
  - state is REQ or WAIT.
- stall is 0 in DONE and while reset=1.
- Byte enables:
  - SB: 0001<<addr[1:0]
  - SH: 0011<<{addr[1],0}
  - SW: 1111
  - mem_be is don't-care on reads but is driven with the same lane pattern.
- Store data: SB → {4{wr_data[7:0]}}, SH → {2{wr_data[15:0]}}, SW → wr_data.
- Load extraction (uses the latched addr[1:0] and func3):
  - LB/LBU: select the byte lane; sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: select the halfword lane; sign-extend (LH) or zero-extend (LHU).
  - Any other func3: full word.

## Timing
- Reset values: state IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata, rd_data, misalign all 0; stall 0.
- Store with immediate gnt occupies 3 cycles: IDLE (stall), REQ (gnt), DONE.
- Load with immediate gnt and rvalid one cycle later occupies 4 cycles: IDLE, REQ, WAIT, DONE.
- Each extra gnt or rvalid wait cycle adds one stall cycle.
- rd_data is valid from the DONE cycle and holds until the next load completes or a misalign clears it.
- Back-to-back requests: a new request is first seen in the IDLE cycle after DONE, so there are no bubbles beyond the state sequence.
- Reset mid-operation: next edge forces IDLE and mem_req=0. A late rvalid is ignored; the memory must tolerate an abandoned request.

## Structure
- Package lsu_pkg holds:
  - state enum {IDLE, REQ, WAIT, DONE}
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101
- One sub-module, lsu_align: combinational. It computes misaligned, be[3:0] and the replicated wdata from (func3, addr[1:0], wr_data), and computes extended load data from (func3, offset, raw word).
- Top level holds the FSM plus the latched offset/func3 registers.

## Test plan
- SW addr=0x010, wr_data=0xDEADBEEF, gnt on first REQ cycle → mem_addr=0x04, be=1111, wdata=0xDEADBEEF, stall high exactly 2 cycles.
- SB addr=0x013, wr_data=0x000000A5 → be=1000, wdata=0xA5A5A5A5.
- LB addr=0x012 then LBU addr=0x012, memory word 0x1280FF34 with rvalid 3 cycles after gnt → rd_data=0xFFFFFF80, then 0x00000080. Stall lasts 5 cycles per load.
- LH addr=0x002, mem word 0x8001_7FFF → 0xFFFF8001. LW addr=0x006 → misalign=1 for 1 cycle, no mem_req, stall=0, rd_data=0.
- gnt withheld 4 cycles → mem_req and all mem_* outputs stable throughout, stall held; completes normally afterwards.
- reset asserted in WAIT, rvalid arrives 1 cycle later → state IDLE, rd_data=0, rvalid ignored, stall=0.
